seg7_scan_capture: RTL and testbench
====================================

SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the number of consecutive identical input samples required before a digit is captured (legal range 2..255).
REQ-002 clk  input  1  single system clock; all state SHALL be clocked on the rising edge of clk.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 seg  input  8  segment bus; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp; 1 = lit.
REQ-005 dig  input  6  digit enables, active-low; dig[0] = rightmost digit.
REQ-006 codes  output  24  captured 4-bit value per digit; codes[4i+3:4i] belongs to digit i.
REQ-007 code_ok  output  6  bit i = 1 when digit i's last capture matched a legal pattern.
REQ-008 dp  output  6  bit i = captured seg[0] of digit i.
REQ-009 frame_done  output  1  one-cycle pulse when all 6 digits have been captured since the previous pulse.
REQ-010 err  output  1  one-cycle pulse on an illegal stable input (see REQ-017, REQ-018).

Function
REQ-011 seg and dig SHALL be registered once (sample stage) before any comparison.
REQ-012 Legal patterns on seg[7:1] (hex of seg[7:0] with dp=0): 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=E6, A=EE, b=3E, c=1A, d=7A, E=9E, F=8E; seg[0] SHALL be excluded from matching.
REQ-013 A stability counter SHALL clear whenever the sampled {seg,dig} differs from the previous sample, and otherwise increment, saturating at STABLE_CYCLES-1.
REQ-014 States: IDLE (no dig bit low), SETTLE (counter below threshold), HELD (capture done for the current stable value); any change of the sampled value SHALL return the block to SETTLE, or to IDLE if dig=6'b111111.
REQ-015 Capture latency: if a new input value is first present at edge k and then held, codes/code_ok/dp SHALL update at edge k+STABLE_CYCLES+1.
REQ-016 Exactly one capture SHALL occur per stable value; holding a digit indefinitely SHALL NOT recapture it.
REQ-017 An unmatched pattern on a single active digit SHALL set that digit's code to 0 and code_ok bit to 0, capture dp, mark the digit as seen, and pulse err.
REQ-018 More than one dig bit low when stable SHALL pulse err, perform no capture, and enter HELD.
REQ-019 A seen mask SHALL accumulate the captured digits; on the capture that completes the mask, frame_done SHALL pulse during the same cycle in which the outputs update, and the mask SHALL clear.
REQ-020 Recapturing an already-seen digit before the frame completes SHALL update its outputs without affecting frame_done.
REQ-021 IDLE (blanking) SHALL NOT alter any outputs or the seen mask.

Reset
REQ-022 On rst: codes=0, code_ok=0, dp=0, frame_done=0, err=0, seen mask=0, counter=0, state=IDLE, sample registers=0/6'b111111, all taking effect immediately, including mid-SETTLE.
REQ-023 The first capture after reset release SHALL require the full STABLE_CYCLES.

Structure
REQ-024 Package seg7_pkg SHALL hold the 16 segment pattern constants, NUM_DIGITS=6, the segment bit indices, and the state encoding.
REQ-025 The pattern match SHALL be a combinational sub-module seg7_pattern_decode (seg[7:1] in; 4-bit code and match flag out), shared with future display blocks.

Verification
REQ-026 Hold seg=8'hDA, dig=6'b111110 from edge 10 with STABLE_CYCLES=4 -> codes[3:0]=2 and code_ok[0]=1 at edge 15, with no change from edge 16 onward.
REQ-027 Scan 0..5 with the values 1,2,3,4,5,6, each held 6 cycles -> frame_done pulses once, on the cycle in which digit 5 is captured, and codes=24'h654321.
REQ-028 Present seg=8'h01 (dp only) on dig=6'b111011 -> err pulses once, code_ok[2]=0, dp[2]=1, codes[11:8]=0.
REQ-029 Present dig=6'b111100 stable -> err pulses once; codes, code_ok and the seen mask are unchanged.
REQ-030 Change seg every 3 cycles with STABLE_CYCLES=4 -> no capture; then assert rst during SETTLE -> all outputs are 0 immediately, and a capture occurs only 5 edges after a stable value is applied post-release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment capture path:
// digit count, segment bit positions, legal glyph patterns and FSM states.
package seg7_pkg;

    localparam int NUM_DIGITS = 6;

    // Bit positions on the segment bus (1 = lit).
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Glyphs 0..F as full bus values with the decimal point off; index = hex value.
    localparam logic [7:0] SEG_PATTERN [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // display blanked, no digit enabled
        ST_SETTLE = 2'd1,   // waiting for the sampled value to stay put
        ST_HELD   = 2'd2    // current stable value already handled
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph decoder: maps segments a..g to a hex value and
// flags whether the pattern is one of the sixteen legal glyphs.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,    // segments a..g (bus bits 7..1)
    output logic [3:0] code_o,
    output logic       match_o
);

    // Search the glyph table; patterns are unique so at most one entry hits.
    always_comb begin
        code_o  = 4'd0;
        match_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_PATTERN[i][7:1]) begin
                code_o  = 4'(i);
                match_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures the digits shown on a scanned, multiplexed 7-segment display.
// Inputs are sampled once, then a value must stay unchanged long enough
// before the enabled digit is decoded and stored exactly once.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig,
    output logic [4*NUM_DIGITS-1:0] codes,
    output logic [NUM_DIGITS-1:0]   code_ok,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic                    frame_done,
    output logic                    err
);

    localparam logic [7:0]            CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF = '1;

    logic [7:0]              seg_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   dig_q, dig_prev_q;
    logic [7:0]              cnt_q, cnt_d;
    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] codes_q, codes_d;
    logic [NUM_DIGITS-1:0]   code_ok_q, code_ok_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    frame_done_q, frame_done_d;
    logic                    err_q, err_d;

    logic                    changed;
    logic [2:0]              low_cnt;
    logic [NUM_DIGITS-1:0]   seen_next;
    logic [3:0]              dec_code;
    logic                    dec_match;

    seg7_pattern_decode u_decode (
        .seg_i   (seg_q[SEG_A:SEG_G]),
        .code_o  (dec_code),
        .match_o (dec_match)
    );

    // Sample stage plus one-deep history used for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q      <= 8'h00;
            dig_q      <= ALL_OFF;
            seg_prev_q <= 8'h00;
            dig_prev_q <= ALL_OFF;
        end else begin
            seg_q      <= seg;
            dig_q      <= dig;
            seg_prev_q <= seg_q;
            dig_prev_q <= dig_q;
        end
    end

    // Control and capture state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= 8'd0;
            state_q      <= ST_IDLE;
            codes_q      <= '0;
            code_ok_q    <= '0;
            dp_q         <= '0;
            seen_q       <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            codes_q      <= codes_d;
            code_ok_q    <= code_ok_d;
            dp_q         <= dp_d;
            seen_q       <= seen_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    // Next state: restart settling on any change, capture once when the
    // counter has saturated while still settling.
    always_comb begin
        cnt_d        = cnt_q;
        state_d      = state_q;
        codes_d      = codes_q;
        code_ok_d    = code_ok_q;
        dp_d         = dp_q;
        seen_d       = seen_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        seen_next    = seen_q | ~dig_q;

        changed = ({seg_q, dig_q} != {seg_prev_q, dig_prev_q});
        low_cnt = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!dig_q[i]) begin
                low_cnt = low_cnt + 3'd1;
            end
        end

        if (changed) begin
            cnt_d   = 8'd0;
            state_d = (dig_q == ALL_OFF) ? ST_IDLE : ST_SETTLE;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end
            if (state_q == ST_SETTLE && cnt_q == CNT_MAX) begin
                state_d = ST_HELD;
                if (low_cnt == 3'd1) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (!dig_q[i]) begin
                            codes_d[4*i +: 4] = dec_match ? dec_code : 4'd0;
                            code_ok_d[i]      = dec_match;
                            dp_d[i]           = seg_q[SEG_DP];
                        end
                    end
                    err_d = !dec_match;
                    if (seen_next == ALL_OFF) begin
                        frame_done_d = 1'b1;
                        seen_d       = '0;
                    end else begin
                        seen_d = seen_next;
                    end
                end else begin
                    // Ghosting: several digits enabled at once is unreadable.
                    err_d = 1'b1;
                end
            end
        end
    end

    assign codes      = codes_q;
    assign code_ok    = code_ok_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: a driver applies held values (directed and
// random), a reference model predicts the outputs after every edge from
// run lengths of identical inputs, and a monitor compares each cycle.
module tb_seg7_scan_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [5:0]  dig;
    logic [23:0] codes;
    logic [5:0]  code_ok;
    logic [5:0]  dp;
    logic        frame_done;
    logic        err;

    always #5 clk = ~clk;

    seg7_scan_capture #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .dig        (dig),
        .codes      (codes),
        .code_ok    (code_ok),
        .dp         (dp),
        .frame_done (frame_done),
        .err        (err)
    );

    typedef struct packed {
        logic [23:0] codes;
        logic [5:0]  ok;
        logic [5:0]  dp;
        logic        fd;
        logic        er;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m = '0;
    logic [5:0]  m_seen = '0;
    logic [13:0] last_v = {8'h00, 6'h3F};
    int          run = 1000;

    logic [7:0] pat [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

    int checks = 0;
    int errors = 0;
    int fd_seen = 0;
    int err_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: a value presented on S+1 consecutive edges is captured at
    // the following edge, exactly once, unless no digit is enabled.
    task model_edge(input logic r, input logic [7:0] s, input logic [5:0] d);
        int  lows, pos, code;
        logic hit;
        if (r) begin
            m      = '0;
            m_seen = '0;
            last_v = {8'h00, 6'h3F};
            run    = 1000;
        end else begin
            m.fd = 1'b0;
            m.er = 1'b0;
            if (run == S + 1 && last_v[5:0] != 6'h3F) begin
                lows = 0;
                pos  = 0;
                for (int i = 0; i < 6; i++) begin
                    if (!last_v[i]) begin
                        lows++;
                        pos = i;
                    end
                end
                if (lows == 1) begin
                    hit  = 1'b0;
                    code = 0;
                    for (int j = 0; j < 16; j++) begin
                        if (pat[j][7:1] == last_v[13:7]) begin
                            hit  = 1'b1;
                            code = j;
                        end
                    end
                    m.codes[4*pos +: 4] = hit ? 4'(code) : 4'd0;
                    m.ok[pos]  = hit;
                    m.dp[pos]  = last_v[6];
                    m.er       = !hit;
                    m_seen[pos] = 1'b1;
                    if (m_seen == 6'h3F) begin
                        m.fd   = 1'b1;
                        m_seen = '0;
                    end
                end else begin
                    m.er = 1'b1;
                end
            end
            if ({s, d} == last_v) begin
                if (run < 1000) run++;
            end else begin
                last_v = {s, d};
                run    = 1;
            end
        end
        exp_q.push_back(m);
    endtask

    // One clock of stimulus; a reset step also checks the asynchronous clear.
    task step(input logic r, input logic [7:0] s, input logic [5:0] d);
        @(negedge clk);
        #2;
        rst = r;
        seg = s;
        dig = d;
        if (r) begin
            #1;
            check("rst_codes", 64'(codes), 64'd0);
            check("rst_flags", 64'({code_ok, dp, frame_done, err}), 64'd0);
        end
        @(posedge clk);
        model_edge(r, s, d);
        #1;
        if (frame_done) fd_seen++;
        if (err) err_seen++;
    endtask

    task hold(input logic [7:0] s, input logic [5:0] d, input int n);
        repeat (n) step(1'b0, s, d);
    endtask

    task monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle_outputs", 64'({codes, code_ok, dp, frame_done, err}), 64'(e));
            end
        end
    endtask

    task driver();
        int         f0, e0, a, b, kind, n;
        logic [7:0] s;
        logic [5:0] d;

        repeat (3) step(1'b1, 8'h00, 6'h3F);
        hold(8'h00, 6'h3F, 4);

        // Single digit latency: capture on the sixth edge of the hold.
        e0 = err_seen;
        hold(8'hDA, 6'b111110, 5);
        check("lat_early", 64'(code_ok[0]), 64'd0);
        step(1'b0, 8'hDA, 6'b111110);
        check("lat_code", 64'(codes[3:0]), 64'd2);
        check("lat_ok", 64'(code_ok[0]), 64'd1);
        hold(8'hDA, 6'b111110, 6);
        check("hold_code", 64'(codes[3:0]), 64'd2);
        check("hold_noerr", 64'(err_seen - e0), 64'd0);
        hold(8'h00, 6'h3F, 3);

        // Full scan 1..6 across digits 0..5.
        f0 = fd_seen;
        for (int i = 0; i < 6; i++) begin
            d = ~(6'd1 << i);
            hold(pat[i+1], d, 6);
        end
        check("scan_fd_now", 64'(frame_done), 64'd1);
        check("scan_codes", 64'(codes), 64'h654321);
        check("scan_fd_count", 64'(fd_seen - f0), 64'd1);
        hold(8'h00, 6'h3F, 3);

        // Decimal point only: illegal glyph on digit 2.
        e0 = err_seen;
        hold(8'h01, 6'b111011, 7);
        check("bad_err", 64'(err_seen - e0), 64'd1);
        check("bad_ok", 64'(code_ok), 64'h3B);
        check("bad_dp", 64'(dp), 64'h04);
        check("bad_codes", 64'(codes), 64'h654021);
        hold(8'h00, 6'h3F, 3);

        // Two digits enabled together.
        e0 = err_seen;
        hold(8'h60, 6'b111100, 8);
        check("ghost_err", 64'(err_seen - e0), 64'd1);
        check("ghost_codes", 64'(codes), 64'h654021);
        check("ghost_ok", 64'(code_ok), 64'h3B);
        hold(8'h00, 6'h3F, 3);

        // Digit 2 is already seen, so digit 5 completes the frame.
        f0 = fd_seen;
        hold(pat[7], 6'b111110, 6);
        hold(pat[8], 6'b111101, 6);
        hold(pat[9], 6'b110111, 6);
        hold(pat[10], 6'b101111, 6);
        check("part_nofd", 64'(fd_seen - f0), 64'd0);
        hold(pat[11], 6'b011111, 6);
        check("part_fd", 64'(fd_seen - f0), 64'd1);
        check("part_codes", 64'(codes), 64'hBA9087);

        // Too fast to settle, then reset mid-settle.
        f0 = fd_seen;
        e0 = err_seen;
        for (int j = 0; j < 6; j++) hold(pat[j], 6'b111110, 3);
        check("fast_codes", 64'(codes), 64'hBA9087);
        check("fast_pulses", 64'(fd_seen - f0 + err_seen - e0), 64'd0);
        hold(8'hF2, 6'b111101, 3);
        step(1'b1, 8'hF2, 6'b111101);
        step(1'b1, 8'hF2, 6'b111101);
        hold(8'hF2, 6'b111101, 5);
        check("post_rst_early", 64'({codes, code_ok}), 64'd0);
        step(1'b0, 8'hF2, 6'b111101);
        check("post_rst_code", 64'(codes), 64'h000030);
        check("post_rst_ok", 64'(code_ok), 64'h02);

        // Random held values, digits, ghosting, blanking and resets.
        for (int blk = 0; blk < 120; blk++) begin
            kind = $urandom_range(0, 9);
            a = $urandom_range(0, 5);
            if (kind == 0) begin
                d = 6'h3F;
            end else if (kind == 1) begin
                b = (a + 1 + $urandom_range(0, 4)) % 6;
                d = 6'($urandom) & ~(6'd1 << a) & ~(6'd1 << b);
            end else begin
                d = ~(6'd1 << a);
            end
            if ($urandom_range(0, 3) == 0) s = 8'($urandom);
            else s = pat[$urandom_range(0, 15)] | 8'($urandom_range(0, 1));
            n = $urandom_range(1, 8);
            if ($urandom_range(0, 39) == 0) step(1'b1, s, d);
            hold(s, d, n);
        end

        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        seg = 8'h00;
        dig = 6'h3F;
        fork
            monitor();
            driver();
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
